// File: rtl/bmac_pkg.sv
// bmac_pkg: shared definitions for the binary dot-product lane.
//   - state_e        : sequencer states {IDLE, RUN, DONE}
//   - DEF_* params   : default widths used by bmac and bmac_dot_seq
//   - min_acc_width(): smallest accumulator width that cannot overflow for
//                      a given length-field width and operand word width
package bmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_IN_WIDTH     = 32;
  localparam int DEF_LUT_WIDTH    = 8;
  localparam int DEF_OUTPUT_WIDTH = 16;
  localparam int DEF_LEN_WIDTH    = 8;
  localparam int DEF_ACC_WIDTH    = 24;

  // Maximum sum is (2^len_w - 1) * in_w. One extra bit keeps the bipolar
  // form 2*acc - len*in_w representable as a signed value.
  function automatic int min_acc_width(input int len_w, input int in_w);
    return len_w + $clog2(in_w + 1) + 1;
  endfunction

endpackage

// File: rtl/bmac.sv
// bmac: combinational binary multiply-accumulate element.
// Counts the bit positions where a_i and b_i agree (XNOR + popcount).
// The count is formed per LUT_WIDTH-bit slice and the slice counts are summed.
// Ports:
//   a_i, b_i   [IN_WIDTH-1:0]     operand words
//   popcount_o [OUTPUT_WIDTH-1:0] number of matching bit positions
module bmac
  import bmac_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int LUT_WIDTH    = DEF_LUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]     a_i,
  input  logic [IN_WIDTH-1:0]     b_i,
  output logic [OUTPUT_WIDTH-1:0] popcount_o
);

  localparam int N_SLICES = IN_WIDTH / LUT_WIDTH;

  if ((IN_WIDTH % LUT_WIDTH) != 0) begin : g_bad_slice
    $error("bmac: IN_WIDTH must be a multiple of LUT_WIDTH");
  end
  if (OUTPUT_WIDTH < $clog2(IN_WIDTH + 1)) begin : g_bad_out
    $error("bmac: OUTPUT_WIDTH too small for IN_WIDTH popcount");
  end

  logic [IN_WIDTH-1:0]     match;
  logic [OUTPUT_WIDTH-1:0] slice_cnt;
  logic [OUTPUT_WIDTH-1:0] total;

  assign match = ~(a_i ^ b_i);

  always_comb begin
    total     = '0;
    slice_cnt = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      slice_cnt = '0;
      for (int b = 0; b < LUT_WIDTH; b++) begin
        slice_cnt = slice_cnt + OUTPUT_WIDTH'(match[s*LUT_WIDTH + b]);
      end
      total = total + slice_cnt;
    end
  end

  assign popcount_o = total;

endmodule

// File: rtl/bmac_dot_seq.sv
// bmac_dot_seq: streams len operand word pairs through one bmac and
// accumulates their popcounts. The final sum is presented on a valid/ready
// result port.
// Optional feature: define BMAC_DOT_SEQ_BIPOLAR_EN to output the signed +-1
// dot product (2*acc - len*IN_WIDTH) instead of the raw match count.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          job request (sampled in IDLE only) and length in words
//   busy                high in RUN and DONE
//   in_valid, in_ready  operand handshake (in_ready high only in RUN)
//   in_a, in_b          operand words
//   out_valid, out_ready, out_data  result handshake and value
module bmac_dot_seq
  import bmac_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int LUT_WIDTH    = DEF_LUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  if (ACC_WIDTH < min_acc_width(LEN_WIDTH, IN_WIDTH)) begin : g_bad_acc
    $error("bmac_dot_seq: ACC_WIDTH too small, accumulator could overflow");
  end

  state_e                state_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [ACC_WIDTH-1:0]  result_q;
  logic                  busy_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
`ifdef BMAC_DOT_SEQ_BIPOLAR_EN
  logic [LEN_WIDTH-1:0]  len_q;
`endif

  logic [OUTPUT_WIDTH-1:0] pop;
  logic                    beat;
  logic [ACC_WIDTH-1:0]    acc_d;
  logic [ACC_WIDTH-1:0]    result_d;

  bmac #(
    .IN_WIDTH    (IN_WIDTH),
    .LUT_WIDTH   (LUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_bmac (
    .a_i       (in_a),
    .b_i       (in_b),
    .popcount_o(pop)
  );

  // in_ready_q is high exactly in RUN, so it doubles as the state qualifier.
  assign beat  = in_valid & in_ready_q;
  assign acc_d = acc_q + ACC_WIDTH'(pop);

  // Result computed from the post-update accumulator so it can be registered
  // on the same edge that accepts the last beat.
  always_comb begin
`ifdef BMAC_DOT_SEQ_BIPOLAR_EN
    result_d = (acc_d << 1) - (ACC_WIDTH'(len_q) * ACC_WIDTH'(IN_WIDTH));
`else
    result_d = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BMAC_DOT_SEQ_BIPOLAR_EN
      len_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
`ifdef BMAC_DOT_SEQ_BIPOLAR_EN
            len_q  <= len;
`endif
            if (len != '0) begin
              cnt_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= RUN;
            end else begin
              // Empty job: the result is zero in both output forms.
              result_q    <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              result_q    <= result_d;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;

endmodule

// File: tb/tb_bmac_dot_seq.sv
// tb_bmac_dot_seq: directed scoreboard bench for bmac_dot_seq.
// Expected results are queued when a job starts. A negedge monitor pops and
// compares them on every out_valid/out_ready transfer.
// Expected values follow BMAC_DOT_SEQ_BIPOLAR_EN when it is defined.
module tb_bmac_dot_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;

  int checks   = 0;
  int failures = 0;
  logic [23:0] expQ[$];

`ifdef BMAC_DOT_SEQ_BIPOLAR_EN
  localparam logic [23:0] EXP_MATCH    = 24'd96;
  localparam logic [23:0] EXP_MISMATCH = 24'hFFFFA0;
  localparam logic [23:0] EXP_BYTE     = 24'd32;
  localparam logic [23:0] EXP_STALL    = 24'd96;
  localparam logic [23:0] EXP_ONE      = 24'd32;
`else
  localparam logic [23:0] EXP_MATCH    = 24'd96;
  localparam logic [23:0] EXP_MISMATCH = 24'd0;
  localparam logic [23:0] EXP_BYTE     = 24'd48;
  localparam logic [23:0] EXP_STALL    = 24'd112;
  localparam logic [23:0] EXP_ONE      = 24'd32;
`endif

  bmac_dot_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer is seen once, at the negedge before the
  // edge that completes it.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected result", 32'(out_data), 32'hFFFFFFFF);
      end else begin
        checkOutput("result", 32'(out_data), 32'(expQ.pop_front()));
      end
    end
  end

  // Runs one job with in_valid held high and out_ready high.
  task automatic applyStimulus(input logic [7:0] l, input logic [31:0] a,
                               input logic [31:0] b, input logic [23:0] expv);
    int cyc;
    expQ.push_back(expv);
    out_ready = 1'b1;
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = '0;
    checkOutput("busy after start", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(l) + 32'd1);
    checkOutput("in_ready low in DONE", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("idle after transfer", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] stallA [0:5];
    logic        stallV [0:5];
    int          k;
    stallA = '{32'h12345670, 32'h0, 32'h89ABCDE0, 32'h0, 32'hCAFEBAB0, 32'h00FF00F0};
    stallV = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] all-match job");
    applyStimulus(8'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, EXP_MATCH);
    $display("[TB] all-mismatch job");
    applyStimulus(8'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, EXP_MISMATCH);
    $display("[TB] partial-match job");
    applyStimulus(8'd2, 32'h00000000, 32'h000000FF, EXP_BYTE);

    $display("[TB] zero-length job");
    out_ready = 1'b0;
    expQ.push_back(24'd0);
    start = 1'b1;
    len = 8'd0;
    tick();
    start = 1'b0;
    checkOutput("len0 busy", 32'(busy), 32'd1);
    checkOutput("len0 out_valid", 32'(out_valid), 32'd1);
    checkOutput("len0 in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("len0 idle", 32'(busy), 32'd0);

    $display("[TB] stalls and backpressure");
    out_ready = 1'b0;
    expQ.push_back(EXP_STALL);
    start = 1'b1;
    len = 8'd4;
    tick();
    start = 1'b0;
    len = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = stallV[i];
      in_a = stallA[i];
      in_b = stallA[i] ^ 32'h0000000F;
      tick();
    end
    in_valid = 1'b1;
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = 8'd2;
      checkOutput("held out_valid", 32'(out_valid), 32'd1);
      checkOutput("held out_data", 32'(out_data), 32'(EXP_STALL));
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("stall idle", 32'(busy), 32'd0);
    tick();
    checkOutput("start in DONE ignored", 32'(busy), 32'd0);

    $display("[TB] reset mid-job");
    start = 1'b1;
    len = 8'd10;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 32'hFFFFFFFF;
    in_b = 32'hFFFFFFFF;
    k = 0;
    while (k < 4) begin
      tick();
      k++;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'd1, 32'hDEADBEEF, 32'hDEADBEEF, EXP_ONE);

    tick();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmac_dot_seq.md
# bmac_dot_seq

Sequencer that computes a binary dot product over a multi-word operand vector. It streams word pairs through one combinational BMAC (XNOR + popcount) instance and accumulates the per-word popcounts. It presents the final sum on a valid/ready result port. It sits between an operand fetch stream and the layer output buffer, and owns the only BMAC datapath in its lane.

## Interface
- IN_WIDTH, 32: bits per operand word; passed to BMAC.
- LUT_WIDTH, 8: popcount LUT slice width; passed to BMAC.
- OUTPUT_WIDTH, 16: BMAC popcount output width.
- LEN_WIDTH, 8: width of the vector length field, in words.
- ACC_WIDTH, 24: accumulator and result width. Elaboration check: ACC_WIDTH >= LEN_WIDTH + $clog2(IN_WIDTH+1) + 1.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: job request pulse; sampled only in IDLE.
- len, input, LEN_WIDTH: job length in words; sampled with start.
- busy, output, 1: high in RUN and DONE.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: high only in RUN.
- in_a, input, IN_WIDTH: operand word A.
- in_b, input, IN_WIDTH: operand word B.
- out_valid, output, 1: result valid; high only in DONE.
- out_ready, input, 1: result consumer ready.
- out_data, output, ACC_WIDTH: dot-product result.

## Operation
- Reset values: state IDLE, acc 0, word counter 0, latched length 0. Outputs: busy 0, in_ready 0, out_valid 0, out_data 0.
- IDLE:
  - start=1 and len!=0: latch len, clear acc, load counter with len, go to RUN.
  - start=1 and len=0: clear acc, go directly to DONE with result 0.
  - start=0: stay.
- RUN:
  - A beat is accepted when in_valid and in_ready are both high. On a beat: acc += BMAC popcount of (in_a, in_b), zero-extended to ACC_WIDTH; counter decrements.
  - The beat that brings the counter to 0 is the last beat; go to DONE.
  - No beat: hold all state.
- DONE:
  - out_data is driven from registered state and stays stable while out_valid=1.
  - Transfer when out_valid and out_ready are both high; go to IDLE.
- start is ignored in RUN and DONE. It is never queued.
- Width: popcount per word is at most IN_WIDTH. The elaboration check guarantees the accumulator cannot overflow, so there is no saturation logic.
- Reset mid-job: rst_n low at any time forces the reset values immediately. The partial job is discarded.

## Timing
- Throughput: one beat per cycle while in_valid is held high.
- Latency: out_valid rises on the cycle after the last beat is accepted. A job of len words with no stalls takes len+1 cycles from the first in_ready to out_valid.
- len=0: out_valid rises on the cycle after start is sampled.
- in_ready drops on the cycle after the last beat. Any extra in_valid during DONE is not consumed.
- Back-to-back jobs: the result transfer returns the block to IDLE on the next edge. The earliest next start is sampled one cycle after the out handshake.
- BMAC is combinational, so the accumulator update is single-cycle with no internal pipeline.

## Configuration
- Macro: BMAC_DOT_SEQ_BIPOLAR_EN.
- Defined: out_data = 2*acc − len_latched*IN_WIDTH, as a signed two's-complement ACC_WIDTH value. This is the ±1 dot product. It is registered on entry to DONE, so latency is unchanged.
- Undefined: out_data = acc, an unsigned match count.

## Structure
- Shared package bmac_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default width constants;
  - the ACC_WIDTH sizing function used by the elaboration check.
- One sub-module: the existing BMAC, instantiated once with IN_WIDTH, LUT_WIDTH and OUTPUT_WIDTH forwarded. The FSM, counter and accumulator live in bmac_dot_seq itself.

## Test plan
- All-match job: len=3, in_a=in_b=32'hA5A5A5A5, continuous valid. Required: out_valid on cycle 4; out_data=96. Bipolar build: 96.
- All-mismatch job: len=3, in_b=~in_a. Required: out_data=0. Bipolar build: −96 (24'hFFFFA0).
- Zero length: start with len=0. Required: busy=1 and out_valid=1 on the next cycle; out_data=0; in_ready never asserted.
- Stalls and backpressure: len=4, in_valid gapped 1-0-1-0-1-1, with in_a^in_b=32'h0000000F each beat (28 matches per beat), and out_ready held low 5 cycles. Required: out_data=112 held stable until out_ready; then IDLE; a start asserted during DONE is ignored.
- Reset mid-job: len=10, assert rst_n=0 after 4 beats. Required: outputs return to reset values immediately. A following len=1 job with in_a=in_b returns 32, proving acc was cleared.
